// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word loads and stores from the execute stage into
// word-wide accesses on the memory-map decoder port. Sub-word stores use read-modify-write.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_*                           core request (accepted only while req_ready is high)
//   resp_valid/resp_data/resp_fault one-cycle completion pulse with extended load data and fault
//   address, memory_out, memory_in  word address, combinational read word, write word
//   write_enable                    write strobe; decoder commits at the end of the cycle
//   read_capable, write_capable     permissions of the currently decoded region
module load_store_unit #(
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_fault,
  output logic [29:0] address,
  input  logic [31:0] memory_out,
  output logic [31:0] memory_in,
  output logic        write_enable,
  input  logic        read_capable,
  input  logic        write_capable
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        write_q, write_d;
  logic [31:0] data_q, data_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [1:0]  resp_fault_q, resp_fault_d;

  logic        misaligned;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] rmw_base;
  logic [31:0] rmw_word;

  assign misaligned = ((req_size == 2'd1) && req_address[0]) ||
                      ((req_size == 2'd2) && (req_address[1:0] != 2'b00));

  // Lane extraction and extension of the read word for loads.
  always_comb begin
    load_byte = memory_out[7:0];
    unique case (addr_q[1:0])
      2'd0: load_byte = memory_out[7:0];
      2'd1: load_byte = memory_out[15:8];
      2'd2: load_byte = memory_out[23:16];
      2'd3: load_byte = memory_out[31:24];
      default: load_byte = memory_out[7:0];
    endcase
    load_half = addr_q[1] ? memory_out[31:16] : memory_out[15:0];
    unique case (size_q)
      2'd0:    load_ext = {{24{~uns_q & load_byte[7]}}, load_byte};
      2'd1:    load_ext = {{16{~uns_q & load_half[15]}}, load_half};
      default: load_ext = memory_out;
    endcase
  end

  // Merge of store data into the current word; write-only regions merge into zero.
  always_comb begin
    rmw_base = read_capable ? memory_out : 32'h0;
    rmw_word = rmw_base;
    if (size_q == 2'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (addr_q[1:0] == 2'(i)) rmw_word[8*i +: 8] = data_q[7:0];
      end
    end else if (addr_q[1]) begin
      rmw_word[31:16] = data_q[15:0];
    end else begin
      rmw_word[15:0] = data_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    write_d      = write_q;
    data_d       = data_q;
    merged_d     = merged_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          write_d = req_write;
          data_d  = req_data;
          // Natural alignment is forced here so a non-faulting misaligned access proceeds.
          unique case (req_size)
            2'd1:    addr_d = {req_address[31:1], 1'b0};
            2'd2:    addr_d = {req_address[31:2], 2'b00};
            default: addr_d = req_address;
          endcase
          if (req_size == 2'd3) begin
            resp_fault_d = 2'd3;
            resp_data_d  = 32'h0;
            state_d      = StResp;
          end else if (misaligned && FAULT_ON_MISALIGN) begin
            resp_fault_d = 2'd1;
            resp_data_d  = 32'h0;
            state_d      = StResp;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        resp_data_d  = 32'h0;
        resp_fault_d = 2'd0;
        state_d      = StResp;
        if (!write_q) begin
          if (read_capable) resp_data_d = load_ext;
          else resp_fault_d = 2'd2;
        end else if (!write_capable) begin
          resp_fault_d = 2'd2;
        end else if (size_q != 2'd2) begin
          merged_d = rmw_word;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        resp_data_d  = 32'h0;
        resp_fault_d = 2'd0;
        state_d      = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= 32'h0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      data_q       <= 32'h0;
      merged_q     <= 32'h0;
      resp_data_q  <= 32'h0;
      resp_fault_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      write_q      <= write_d;
      data_q       <= data_d;
      merged_q     <= merged_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;
  assign address    = ((state_q == StAccess) || (state_q == StWrite)) ? addr_q[31:2] : 30'h0;

  // Reset gates the strobe directly so a write caught mid-flight never commits.
  assign write_enable = !reset &&
                        (((state_q == StAccess) && write_q && (size_q == 2'd2) && write_capable) ||
                         (state_q == StWrite));
  assign memory_in = !write_enable ? 32'h0 : ((state_q == StWrite) ? merged_q : data_q);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  // DUT with misalign faults
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_address, req_data, resp_data, memory_out, memory_in;
  logic [1:0]  req_size, resp_fault;
  logic        resp_valid, write_enable, read_capable, write_capable;
  logic [29:0] address;
  // DUT with alignment forcing
  logic        m2_req_valid, m2_req_ready, m2_req_write, m2_req_unsigned;
  logic [31:0] m2_req_address, m2_req_data, m2_resp_data, m2_memory_out, m2_memory_in;
  logic [1:0]  m2_req_size, m2_resp_fault;
  logic        m2_resp_valid, m2_write_enable, m2_read_capable, m2_write_capable;
  logic [29:0] m2_address;

  load_store_unit #(.FAULT_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_data(req_data), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_fault(resp_fault), .address(address),
    .memory_out(memory_out), .memory_in(memory_in), .write_enable(write_enable),
    .read_capable(read_capable), .write_capable(write_capable)
  );

  load_store_unit #(.FAULT_ON_MISALIGN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .req_valid(m2_req_valid), .req_ready(m2_req_ready),
    .req_write(m2_req_write), .req_address(m2_req_address), .req_size(m2_req_size),
    .req_unsigned(m2_req_unsigned), .req_data(m2_req_data), .resp_valid(m2_resp_valid),
    .resp_data(m2_resp_data), .resp_fault(m2_resp_fault), .address(m2_address),
    .memory_out(m2_memory_out), .memory_in(m2_memory_in), .write_enable(m2_write_enable),
    .read_capable(m2_read_capable), .write_capable(m2_write_capable)
  );

  // Decoder model: RAM at 0x8000_0000 (rw), progmem at 0x0 (ro), IO at 0xFFFF_0000 (wo).
  logic [31:0] ram [16];
  logic sel_ram, sel_prog, sel_io;
  always_comb begin
    sel_ram       = (address[29:26] == 4'b1000);
    sel_prog      = (address[29:16] == 14'd0);
    sel_io        = (address[29:14] == 16'hFFFF);
    read_capable  = sel_ram | sel_prog;
    write_capable = sel_ram | sel_io;
    memory_out    = sel_ram ? ram[address[3:0]] : (sel_prog ? 32'h00000013 : 32'h0);
  end
  always @(posedge clk) if (write_enable && sel_ram) ram[address[3:0]] <= memory_in;

  assign m2_memory_out    = 32'hCAFEBABE;
  assign m2_read_capable  = 1'b1;
  assign m2_write_capable = 1'b1;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [1:0]  fault;
    int          cyc;
    int          we;
    logic [29:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the faulting DUT: tracks write strobes and checks each response.
  initial begin
    exp_t e;
    int we_cnt;
    logic [29:0] we_addr;
    logic [31:0] we_data;
    we_cnt = 0;
    we_addr = '0;
    we_data = '0;
    forever begin
      @(negedge clk);
      if (write_enable) begin
        we_cnt++;
        we_addr = address;
        we_data = memory_in;
      end
      if (resp_valid) begin
        if (q1.size() == 0) begin
          chk("unexpected resp", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          chk($sformatf("t%0d data", e.id), resp_data, e.data);
          chk($sformatf("t%0d fault", e.id), {30'd0, resp_fault}, {30'd0, e.fault});
          chk($sformatf("t%0d latency", e.id), cyc, e.cyc);
          chk($sformatf("t%0d we count", e.id), we_cnt, e.we);
          if (e.we == 1) begin
            chk($sformatf("t%0d we addr", e.id), {2'b0, we_addr}, {2'b0, e.wa});
            chk($sformatf("t%0d we data", e.id), we_data, e.wd);
          end
          chk($sformatf("t%0d resp addr", e.id), {2'b0, address}, 32'd0);
          chk($sformatf("t%0d resp mem_in", e.id), memory_in, 32'd0);
        end
        we_cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m2_resp_valid) begin
        if (q2.size() == 0) begin
          chk("m2 unexpected resp", 32'd1, 32'd0);
        end else begin
          e = q2.pop_front();
          chk($sformatf("m2 t%0d data", e.id), m2_resp_data, e.data);
          chk($sformatf("m2 t%0d fault", e.id), {30'd0, m2_resp_fault}, {30'd0, e.fault});
          chk($sformatf("m2 t%0d latency", e.id), cyc, e.cyc);
          chk($sformatf("m2 t%0d idle port", e.id),
              {m2_write_enable, 1'b0, m2_address} | m2_memory_in, 32'd0);
        end
      end
    end
  end

  task automatic wait_resp(input bit on2);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((!on2 && resp_valid) || (on2 && m2_resp_valid)) begin
        done = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    m2_req_valid = 1'b0;
    if (!done) chk("resp timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input int id, input bit on2, input bit wr, input logic [31:0] a,
                       input logic [1:0] sz, input bit uns, input logic [31:0] d,
                       input logic [31:0] xdata, input logic [1:0] xfault, input int lat,
                       input int xwe, input logic [29:0] xwa, input logic [31:0] xwd);
    exp_t e;
    @(negedge clk);
    if (!on2) begin
      chk($sformatf("t%0d ready", id), {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_address = a; req_size = sz;
      req_unsigned = uns; req_data = d;
    end else begin
      chk($sformatf("m2 t%0d ready", id), {31'd0, m2_req_ready}, 32'd1);
      m2_req_valid = 1'b1; m2_req_write = wr; m2_req_address = a; m2_req_size = sz;
      m2_req_unsigned = uns; m2_req_data = d;
    end
    @(posedge clk);
    #1;
    e.id = id; e.data = xdata; e.fault = xfault; e.cyc = cyc + lat - 1;
    e.we = xwe; e.wa = xwa; e.wd = xwd;
    if (!on2) begin
      q1.push_back(e);
      // Keep a junk store request asserted while busy; it must be ignored.
      req_write = 1'b1; req_address = 32'h80000014; req_size = 2'd2; req_data = 32'hBAD0BAD0;
    end else begin
      q2.push_back(e);
    end
    wait_resp(on2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_size = '0;
    req_unsigned = 1'b0; req_data = '0;
    m2_req_valid = 1'b0; m2_req_write = 1'b0; m2_req_address = '0; m2_req_size = '0;
    m2_req_unsigned = 1'b0; m2_req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset we", {31'd0, write_enable}, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset ready", {31'd0, req_ready}, 32'd1);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset resp_fault", {30'd0, resp_fault}, 32'd0);
    chk("reset address", {2'b0, address}, 32'd0);

    // Word store then load
    issue(1, 0, 1, 32'h80000010, 2, 0, 32'hDEADBEEF, 32'h0, 0, 2, 1, 30'h20000004, 32'hDEADBEEF);
    issue(2, 0, 0, 32'h80000010, 2, 0, 32'h0, 32'hDEADBEEF, 0, 2, 0, '0, '0);
    // Sub-word read-modify-write and extension
    issue(3, 0, 1, 32'h80000010, 2, 0, 32'h11223344, 32'h0, 0, 2, 1, 30'h20000004, 32'h11223344);
    issue(4, 0, 1, 32'h80000013, 0, 0, 32'h123456A5, 32'h0, 0, 3, 1, 30'h20000004, 32'hA5223344);
    issue(5, 0, 0, 32'h80000013, 0, 0, 32'h0, 32'hFFFFFFA5, 0, 2, 0, '0, '0);
    issue(6, 0, 0, 32'h80000013, 0, 1, 32'h0, 32'h000000A5, 0, 2, 0, '0, '0);
    issue(7, 0, 0, 32'h80000012, 1, 0, 32'h0, 32'hFFFFA522, 0, 2, 0, '0, '0);
    issue(8, 0, 1, 32'h80000010, 1, 0, 32'h12347E01, 32'h0, 0, 3, 1, 30'h20000004, 32'hA5227E01);
    issue(9, 0, 0, 32'h80000010, 1, 1, 32'h0, 32'h00007E01, 0, 2, 0, '0, '0);
    issue(10, 0, 0, 32'h80000011, 0, 0, 32'h0, 32'h0000007E, 0, 2, 0, '0, '0);
    issue(11, 0, 0, 32'h80000010, 2, 0, 32'h0, 32'hA5227E01, 0, 2, 0, '0, '0);
    // Misalignment
    issue(12, 0, 0, 32'h80000001, 1, 0, 32'h0, 32'h0, 1, 1, 0, '0, '0);
    issue(13, 0, 1, 32'h80000012, 2, 0, 32'h77777777, 32'h0, 1, 1, 0, '0, '0);
    issue(14, 1, 0, 32'h80000001, 1, 0, 32'h0, 32'hFFFFBABE, 0, 2, 0, '0, '0);
    issue(15, 1, 0, 32'h80000003, 2, 0, 32'h0, 32'hCAFEBABE, 0, 2, 0, '0, '0);
    // Access faults and illegal size
    issue(16, 0, 1, 32'h00000100, 2, 0, 32'h00000055, 32'h0, 2, 2, 0, '0, '0);
    issue(17, 0, 0, 32'h00000100, 2, 0, 32'h0, 32'h00000013, 0, 2, 0, '0, '0);
    issue(18, 0, 0, 32'hFFFF0000, 2, 0, 32'h0, 32'h0, 2, 2, 0, '0, '0);
    issue(19, 0, 0, 32'h80000010, 3, 0, 32'h0, 32'h0, 3, 1, 0, '0, '0);
    issue(20, 0, 1, 32'h80000010, 3, 0, 32'h99999999, 32'h0, 3, 1, 0, '0, '0);
    // Write-only IO sub-word stores merge into zero
    issue(21, 0, 1, 32'hFFFF0004, 0, 0, 32'hFFFFFF41, 32'h0, 0, 3, 1, 30'h3FFFC001, 32'h00000041);
    issue(22, 0, 1, 32'hFFFF0006, 1, 0, 32'h0000BEEF, 32'h0, 0, 3, 1, 30'h3FFFC001, 32'hBEEF0000);

    // Reset during the WRITE cycle of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h80000011; req_size = 2'd0;
    req_unsigned = 1'b0; req_data = 32'h00000099;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("write cycle we", {31'd0, write_enable}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset write we", {31'd0, write_enable}, 32'd0);
    chk("reset write mem_in", memory_in, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post reset ready", {31'd0, req_ready}, 32'd1);
    chk("post reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("post reset resp_data", resp_data, 32'd0);
    issue(23, 0, 0, 32'h80000010, 2, 0, 32'h0, 32'hA5227E01, 0, 2, 0, '0, '0);

    repeat (3) @(negedge clk);
    chk("q1 drained", q1.size(), 32'd0);
    chk("q2 drained", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
